// File: rtl/mimosa_uart_tx_arbiter.sv
// rtl/mimosa_uart_tx_arbiter.sv - shares one 8N1 UART TX between debug-bus snapshots and a byte stream
// Optional macro DEBUG_TAG_EN: each debug grant sends TAG_BYTE followed by the snapshot.
module mimosa_uart_tx_arbiter #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] TAG_BYTE     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] debug,
  input  logic       dbg_en,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_dbg,
  output logic [7:0] drop_cnt
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    debug_q;
  logic [7:0]    snap;
  logic          dbg_pend;
  logic          last_dbg;
  logic          capture;
  logic          win_dbg;
  logic          win_s;
  logic          bit_end;

`ifdef DEBUG_TAG_EN
  logic [7:0] snap_hold;
  logic       tag_second;
`else
  logic [7:0] unused_tag;
  assign unused_tag = TAG_BYTE;
`endif

  assign capture = dbg_en && (debug != debug_q);
  assign bit_end = (baud_cnt == BIT_LAST);
  assign s_ready = win_s;

  // Arbitration only happens between frames; on a tie the source not served last wins.
  always_comb begin
    win_dbg = 1'b0;
    win_s   = 1'b0;
    if (rst_n && state == IDLE) begin
      case ({dbg_pend, s_valid})
        2'b10:   win_dbg = 1'b1;
        2'b01:   win_s   = 1'b1;
        2'b11: begin
          win_s   = last_dbg;
          win_dbg = !last_dbg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      debug_q  <= 8'h00;
      snap     <= 8'h00;
      dbg_pend <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      debug_q <= debug;
      if (capture) begin
        snap     <= debug;
        dbg_pend <= 1'b1;
        if (dbg_pend && !win_dbg && drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (win_dbg) begin
        dbg_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      grant_dbg  <= 1'b0;
      last_dbg   <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
`ifdef DEBUG_TAG_EN
      snap_hold  <= 8'h00;
      tag_second <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (win_dbg || win_s) begin
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
            grant_dbg <= win_dbg;
            last_dbg  <= win_dbg;
`ifdef DEBUG_TAG_EN
            // Snapshot is frozen here so the second frame ignores later bus activity.
            if (win_dbg) begin
              shreg      <= TAG_BYTE;
              snap_hold  <= snap;
              tag_second <= 1'b1;
            end else begin
              shreg      <= s_data;
              tag_second <= 1'b0;
            end
`else
            shreg <= win_dbg ? snap : s_data;
`endif
          end else begin
            busy      <= 1'b0;
            grant_dbg <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= DATA;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
`ifdef DEBUG_TAG_EN
            if (tag_second) begin
              state      <= START;
              tx         <= 1'b0;
              shreg      <= snap_hold;
              tag_second <= 1'b0;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              grant_dbg <= 1'b0;
            end
`else
            state     <= IDLE;
            busy      <= 1'b0;
            grant_dbg <= 1'b0;
`endif
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mimosa_uart_tx_arbiter.sv
// tb/tb_mimosa_uart_tx_arbiter.sv - bench for mimosa_uart_tx_arbiter: frame-level model plus directed scenarios
// Honours DEBUG_TAG_EN when the design is built with it.
module tb_mimosa_uart_tx_arbiter;

  localparam int C  = 4;
  localparam int FL = 10 * C;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] debug   = 8'h00;
  logic       dbg_en  = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       tx;
  logic       busy;
  logic       grant_dbg;
  logic [7:0] drop_cnt;

  int checks = 0;
  int passed = 0;

  mimosa_uart_tx_arbiter #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .debug(debug), .dbg_en(dbg_en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .tx(tx),
    .busy(busy), .grant_dbg(grant_dbg), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a frame is a timeline of m_len cycles; line level derives from position and byte.
  bit         m_ok = 0;
  bit         m_active, m_pend, m_last_dbg, m_src_dbg;
  int         m_pos, m_len;
  logic [7:0] m_b0, m_b1, m_snap, m_prev, m_drop;

  always @(posedge clk) begin : model
    bit acc_d, acc_s, cap;
    if (!rst_n) begin
      m_ok = 1; m_active = 0; m_pos = 0; m_len = FL; m_pend = 0;
      m_last_dbg = 0; m_src_dbg = 0; m_snap = 0; m_prev = 0; m_drop = 0;
      m_b0 = 0; m_b1 = 0;
    end else if (m_ok) begin
      acc_d = 0; acc_s = 0;
      if (m_active) begin
        m_pos++;
        if (m_pos == m_len) m_active = 0;
      end else begin
        acc_d = m_pend && (!s_valid || !m_last_dbg);
        acc_s = s_valid && !acc_d;
        if (acc_d || acc_s) begin
          m_active = 1; m_pos = 0; m_src_dbg = acc_d; m_last_dbg = acc_d;
          if (acc_s) begin
            m_b0 = s_data; m_len = FL;
          end else begin
`ifdef DEBUG_TAG_EN
            m_b0 = 8'hA5; m_b1 = m_snap; m_len = 2 * FL;
`else
            m_b0 = m_snap; m_len = FL;
`endif
          end
        end
      end
      cap = dbg_en && (debug != m_prev);
      if (cap) begin
        if (m_pend && !acc_d && m_drop != 8'hFF) m_drop++;
        m_snap = debug; m_pend = 1;
      end else if (acc_d) begin
        m_pend = 0;
      end
      m_prev = debug;
    end
  end

  function automatic logic exp_tx();
    int q, b;
    logic [7:0] by;
    if (!m_active) return 1'b1;
    q  = m_pos % FL;
    b  = q / C;
    by = (m_pos >= FL) ? m_b1 : m_b0;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      chk("tx", tx, exp_tx());
      chk("busy", busy, m_active);
      chk("s_ready", s_ready, rst_n && !m_active && s_valid && !(m_pend && !m_last_dbg));
      chk("drop_cnt", drop_cnt, m_drop);
      if (m_active) chk("grant_dbg", grant_dbg, m_src_dbg);
    end
  end

  // Line decoder: recovers bytes and busy run lengths from the DUT pins.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         runs[$];
  int         lg_cyc = 0;
  int         sr_cnt = 0;
  bit         lg_prev = 0;
  logic [7:0] lg_sh = 8'h00;

  always @(negedge clk) begin : logger
    int q;
    if (s_ready === 1'b1) sr_cnt++;
    if (busy === 1'b1) begin
      if (!lg_prev) lg_cyc = 0;
      q = lg_cyc % FL;
      if (q % C == C / 2 && q / C >= 1 && q / C <= 8) lg_sh[q/C-1] = tx;
      if (q == 9 * C + C / 2) rx_q.push_back(lg_sh);
      lg_cyc++;
      lg_prev = 1;
    end else begin
      if (lg_prev) runs.push_back(lg_cyc);
      lg_prev = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input logic [7:0] d);
    int t;
    t = 0;
    s_data = d; s_valid = 1'b1;
    @(negedge clk);
    while (s_ready !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("handshake_timeout", t < 500, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", t < 1000, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_rx(input string name);
    chk({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk(name, rx_q[i], exp_q[i]);
    rx_q.delete(); exp_q.delete();
  endtask

  initial begin : stim
    int bc;
    rst_n = 1'b0;
    step(3);
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0); chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    step(5);
    chk("idle_tx", tx, 1); chk("idle_busy", busy, 0); chk("idle_s_ready", s_ready, 0);

    // Single stream byte 0x55
    rx_q.delete(); runs.delete(); sr_cnt = 0;
    send_stream(8'h55);
    wait_idle();
    chk("t1_sready_pulses", sr_cnt, 1);
    chk("t1_busy_len", runs.size() > 0 ? runs[0] : -1, 40);
    exp_q.push_back(8'h55);
    chk_rx("t1_byte");

    // Debug pending and stream valid together: debug first, stream back-to-back
    runs.delete();
    dbg_en = 1'b1; debug = 8'h7E;
    step(1);
    send_stream(8'h11);
    wait_idle();
`ifdef DEBUG_TAG_EN
    exp_q.push_back(8'hA5);
    chk("t2_dbg_len", runs.size() > 0 ? runs[0] : -1, 80);
`else
    chk("t2_dbg_len", runs.size() > 0 ? runs[0] : -1, 40);
`endif
    exp_q.push_back(8'h7E); exp_q.push_back(8'h11);
    chk_rx("t2_order");
    chk("t2_runs", runs.size(), 2);

    // Debug steps during a stream frame: only the last value goes out, two drops
    send_stream(8'hAA);
    step(3); debug = 8'h01;
    step(2); debug = 8'h02;
    step(2); debug = 8'h03;
    step(FL + 5);
    wait_idle();
    exp_q.push_back(8'hAA);
`ifdef DEBUG_TAG_EN
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back(8'h03);
    chk_rx("t3_bytes");
    chk("t3_drop", drop_cnt, 2);

    // Reset during data bit 3 aborts the frame
    dbg_en = 1'b0; debug = 8'h00;
    step(2);
    send_stream(8'hF0);
    step(4 * C + 1);
    rst_n = 1'b0;
    step(1);
    chk("t4_tx", tx, 1); chk("t4_busy", busy, 0); chk("t4_drop", drop_cnt, 0);
    rst_n = 1'b1;
    bc = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
    end
    chk("t4_no_resume", bc, 0);
    chk_rx("t4_none");

    // Debug 0x3C with a waiting stream byte
    @(posedge clk); #1;
    runs.delete();
    dbg_en = 1'b1; debug = 8'h3C;
    step(1);
    send_stream(8'h77);
    wait_idle();
`ifdef DEBUG_TAG_EN
    exp_q.push_back(8'hA5);
    chk("t5_dbg_len", runs.size() > 0 ? runs[0] : -1, 80);
`else
    chk("t5_dbg_len", runs.size() > 0 ? runs[0] : -1, 40);
`endif
    exp_q.push_back(8'h3C); exp_q.push_back(8'h77);
    chk_rx("t5_order");

    step(3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
